// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: chunk-width helper, the per-stage control
// record carried down the adder pipeline, and the subtract-mode encoding.
package arith_pkg;

    // Value of the 'sub' input that selects A - B - cin.
    localparam logic SUB_MODE = 1'b1;

    // Width of one pipeline chunk when 'width' bits are split over 'stages'.
    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    // Per-stage record: beat valid, carry out of the chunk just added, and
    // the operand sign bits needed for the overflow flag at the end.
    // The result-so-far and remaining operand chunks change width from stage
    // to stage, so they are held beside this record in each stage.
    typedef struct packed {
        logic valid;
        logic carry;
        logic a_msb;
        logic bx_msb;
    } stage_ctrl_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CW-bit ripple-carry adder built from FullAdder cells.
module adder_chunk #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout
);
    // Each bit keeps its own carry net so the chain is a plain ripple.
    for (genvar gi = 0; gi < CW; gi++) begin : g_bit
        logic ci;
        logic co;

        if (gi == 0) begin : g_ci
            assign ci = cin;
        end else begin : g_ci
            assign ci = g_bit[gi-1].co;
        end

        FullAdder u_fa (
            .a  (a[gi]),
            .b  (b[gi]),
            .ci (ci),
            .s  (sum[gi]),
            .co (co)
        );
    end

    assign cout = g_bit[CW-1].co;
endmodule

// File: rtl/full_adder.sv
// Single-bit full adder primitive.
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor with valid/ready on both sides.
// WIDTH is cut into STAGES chunks; chunk k is added in stage k and the carry
// is registered between stages. Optional 'zero' output is enabled by the
// macro PIPELINED_ADDER_ZERO_FLAG_EN.
module pipelined_adder
    import arith_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef PIPELINED_ADDER_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);
    localparam int CW = chunk_width(WIDTH, STAGES);

    // Subtraction is A + ~B + ~cin: invert B here and the carry-in below.
    logic             sub_en;
    logic [WIDTH-1:0] bx_in;
    assign sub_en = (sub == SUB_MODE);
    assign bx_in  = b ^ {WIDTH{sub_en}};

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        // Operand bits still to be added, with chunk gi in the low CW bits.
        localparam int UPW = WIDTH - gi * CW;

        logic [UPW-1:0]        src_a_up;
        logic [UPW-1:0]        src_bx_up;
        stage_ctrl_t           src_ctrl;
        logic [(gi+1)*CW-1:0]  next_res;
        logic [CW-1:0]         chunk_sum;
        logic                  chunk_cout;
        logic                  advance;
        logic                  load;
        stage_ctrl_t           ctrl_reg;
        logic [(gi+1)*CW-1:0]  res_reg;

        if (gi == 0) begin : g_src
            assign src_a_up        = a;
            assign src_bx_up       = bx_in;
            assign src_ctrl.valid  = in_valid;
            assign src_ctrl.carry  = cin ^ sub_en;
            assign src_ctrl.a_msb  = a[WIDTH-1];
            assign src_ctrl.bx_msb = bx_in[WIDTH-1];
            assign next_res        = chunk_sum;
        end else begin : g_src
            assign src_a_up  = g_stage[gi-1].g_up.a_up_reg;
            assign src_bx_up = g_stage[gi-1].g_up.bx_up_reg;
            assign src_ctrl  = g_stage[gi-1].ctrl_reg;
            assign next_res  = {chunk_sum, g_stage[gi-1].res_reg};
        end

        adder_chunk #(.CW(CW)) u_chunk (
            .a    (src_a_up[CW-1:0]),
            .b    (src_bx_up[CW-1:0]),
            .cin  (src_ctrl.carry),
            .sum  (chunk_sum),
            .cout (chunk_cout)
        );

        // A stage may move on when the next one is empty or itself moving;
        // the last stage moves when downstream takes the result.
        if (gi == STAGES - 1) begin : g_adv
            assign advance = out_ready;
        end else begin : g_adv
            assign advance = g_stage[gi+1].load;
        end
        assign load = !ctrl_reg.valid || advance;

        // Stage register: take the upstream beat (or bubble) when the slot frees up.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ctrl_reg <= '0;
                res_reg  <= '0;
            end else if (load) begin
                ctrl_reg.valid <= src_ctrl.valid;
                if (src_ctrl.valid) begin
                    ctrl_reg.carry  <= chunk_cout;
                    ctrl_reg.a_msb  <= src_ctrl.a_msb;
                    ctrl_reg.bx_msb <= src_ctrl.bx_msb;
                    res_reg         <= next_res;
                end
            end
        end

        if (gi < STAGES - 1) begin : g_up
            logic [UPW-CW-1:0] a_up_reg;
            logic [UPW-CW-1:0] bx_up_reg;

            // Carry the not-yet-added operand chunks forward with the beat.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_up_reg  <= '0;
                    bx_up_reg <= '0;
                end else if (load && src_ctrl.valid) begin
                    a_up_reg  <= src_a_up[UPW-1:CW];
                    bx_up_reg <= src_bx_up[UPW-1:CW];
                end
            end
        end

`ifdef PIPELINED_ADDER_ZERO_FLAG_EN
        logic src_zero;
        logic zero_reg;

        if (gi == 0) begin : g_zsrc
            assign src_zero = 1'b1;
        end else begin : g_zsrc
            assign src_zero = g_stage[gi-1].zero_reg;
        end

        // Accumulate "all result chunks so far are zero" alongside the beat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                zero_reg <= 1'b0;
            end else if (load && src_ctrl.valid) begin
                zero_reg <= src_zero & ~(|chunk_sum);
            end
        end
`endif
    end

    assign in_ready  = g_stage[0].load;
    assign out_valid = g_stage[STAGES-1].ctrl_reg.valid;
    assign sum       = g_stage[STAGES-1].res_reg;
    assign cout      = g_stage[STAGES-1].ctrl_reg.carry;
    assign ovf       = (g_stage[STAGES-1].ctrl_reg.a_msb == g_stage[STAGES-1].ctrl_reg.bx_msb) &&
                       (sum[WIDTH-1] != g_stage[STAGES-1].ctrl_reg.a_msb);

`ifdef PIPELINED_ADDER_ZERO_FLAG_EN
    assign zero = g_stage[STAGES-1].zero_reg && out_valid;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed testbench for pipelined_adder (WIDTH=32, STAGES=4).
// Build with PIPELINED_ADDER_ZERO_FLAG_EN defined to also exercise 'zero'.
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
`ifdef PIPELINED_ADDER_ZERO_FLAG_EN
    logic        zero;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vec[17];

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
`ifdef PIPELINED_ADDER_ZERO_FLAG_EN
        ,
        .zero      (zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] flags_now();
`ifdef PIPELINED_ADDER_ZERO_FLAG_EN
        return {zero, cout, ovf};
`else
        return {1'b0, cout, ovf};
`endif
    endfunction

    function automatic logic [2:0] flags_exp(input int i);
`ifdef PIPELINED_ADDER_ZERO_FLAG_EN
        return {vec[i].zero, vec[i].cout, vec[i].ovf};
`else
        return {1'b0, vec[i].cout, vec[i].ovf};
`endif
    endfunction

    // Drive vec[first..first+count-1] back to back, drop out_ready over cycles
    // stall_lo..stall_hi, and compare each output transfer in order.
    task automatic run_beats(input string name, input int first, input int count,
                             input int stall_lo, input int stall_hi,
                             input bit chk_lat, input bit chk_fill, input int budget);
        int sent = 0;
        int got  = 0;
        int t    = 0;
        bit seen_full = 1'b0;
        int acc_cyc[$];
        while ((got < count) && (t < budget)) begin
            @(negedge clk);
            out_ready = !((t >= stall_lo) && (t <= stall_hi));
            if (sent < count) begin
                in_valid = 1'b1;
                a   = vec[first+sent].a;
                b   = vec[first+sent].b;
                cin = vec[first+sent].cin;
                sub = vec[first+sent].sub;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                $display("%s beat %0d: sum=0x%08h cout=%0b ovf=%0b", name, got, sum, cout, ovf);
                check($sformatf("%s sum[%0d]", name, got), 64'(sum), 64'(vec[first+got].sum));
                check($sformatf("%s flags[%0d]", name, got), 64'(flags_now()), 64'(flags_exp(first+got)));
                if (chk_lat)
                    check($sformatf("%s latency[%0d]", name, got), 64'(t - acc_cyc[got]), 64'd4);
                got++;
            end
            if (in_valid && in_ready) begin
                acc_cyc.push_back(t);
                sent++;
            end else if (in_valid && chk_fill && !seen_full) begin
                seen_full = 1'b1;
                check($sformatf("%s beats held at stall", name), 64'(sent), 64'd4);
            end
            t++;
        end
        if (got < count)
            check($sformatf("%s timeout results", name), 64'(got), 64'(count));
        if (chk_fill && !seen_full)
            check($sformatf("%s in_ready never dropped", name), 64'd1, 64'd0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int extra;
        //          a             b             cin   sub   sum           cout  ovf   zero
        vec[0]  = '{32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0, 1'b0};
        vec[1]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vec[2]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vec[3]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vec[4]  = '{32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0};
        vec[5]  = '{32'h10000000, 32'h20000000, 1'b0, 1'b0, 32'h30000000, 1'b0, 1'b0, 1'b0};
        vec[6]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
        vec[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
        vec[8]  = '{32'h00000010, 32'h00000001, 1'b0, 1'b1, 32'h0000000F, 1'b1, 1'b0, 1'b0};
        vec[9]  = '{32'h00000001, 32'h00000002, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vec[10] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0};
        vec[11] = '{32'h000000FF, 32'h00000000, 1'b1, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
        vec[12] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vec[13] = '{32'h00000064, 32'h00000032, 1'b1, 1'b1, 32'h00000031, 1'b1, 1'b0, 1'b0};
        vec[14] = '{32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
        vec[15] = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vec[16] = '{32'h00000005, 32'h00000004, 1'b0, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        // Reset state.
        @(negedge clk); @(negedge clk); #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset sum", 64'(sum), 64'd0);
        check("reset cout/ovf", 64'({cout, ovf}), 64'd0);

        // Simple add, full carry ripple, signed overflow cases.
        run_beats("t1", 0, 1, -1, -1, 1'b1, 1'b0, 40);
        run_beats("t2", 1, 1, -1, -1, 1'b1, 1'b0, 40);
        run_beats("t3", 2, 2, -1, -1, 1'b1, 1'b0, 40);

        // Back-to-back stream with backpressure on cycles 3..9.
        run_beats("t4", 4, 10, 3, 9, 1'b0, 1'b1, 200);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (out_valid) extra++;
        end
        check("t4 duplicate results", 64'(extra), 64'd0);

        // Reset with three beats in flight, one already at the output.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            a = 32'h100 + 32'(i); b = 32'h1; cin = 1'b0; sub = 1'b0;
        end
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); #1;
        check("t5 out_valid before reset", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5 out_valid in reset", 64'(out_valid), 64'd0);
        check("t5 in_ready in reset", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (out_valid) extra++;
        end
        check("t5 stale beats", 64'(extra), 64'd0);
        run_beats("t5", 14, 1, -1, -1, 1'b1, 1'b0, 40);

`ifdef PIPELINED_ADDER_ZERO_FLAG_EN
        // Zero flag on an exact-cancel subtraction and a non-zero neighbour.
        run_beats("t6", 15, 2, -1, -1, 1'b1, 1'b0, 40);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
